// File: rtl/zeroriscy_defines.sv
// Core-wide RV32 major opcodes shared by decoder, tracer and stimulus generators.
package zeroriscy_defines;
  localparam logic [6:0] OPCODE_SYSTEM = 7'h73;
  localparam logic [6:0] OPCODE_FENCE  = 7'h0f;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_OPIMM  = 7'h13;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6f;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
endpackage

// File: rtl/zeroriscy_instr_gen_pkg.sv
// Symbolic RV32IM operations, funct fields and per-format word builders for the instruction generator.
package zeroriscy_instr_gen_defines;
  import zeroriscy_defines::*;

  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ECALL, OP_EBREAK, OP_MRET, OP_WFI,
    OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
    OP_MMULT32
  } instr_op_e;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100, F3_SR  = 3'b101, F3_OR  = 3'b110, F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100, F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110, F3_BGEU = 3'b111;
  localparam logic [2:0] F3_B    = 3'b000, F3_H   = 3'b001, F3_W   = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100, F3_HU  = 3'b101;
  localparam logic [2:0] F3_MUL  = 3'b000, F3_MULH = 3'b001, F3_MULHSU = 3'b010, F3_MULHU = 3'b011;
  localparam logic [2:0] F3_DIV  = 3'b100, F3_DIVU = 3'b101, F3_REM = 3'b110, F3_REMU = 3'b111;
  localparam logic [2:0] F3_CSRRW  = 3'b001, F3_CSRRS  = 3'b010, F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101, F3_CSRRSI = 3'b110, F3_CSRRCI = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000, F3_FENCE = 3'b000, F3_MMULT32 = 3'b101;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
  localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:1] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] enc_u(logic [31:12] imm, logic [4:0] rd, logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:1] imm, logic [4:0] rd, logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction
endpackage

// File: rtl/zeroriscy_instr_fifo.sv
// DEPTH x WIDTH synchronous FIFO with flush; write-to-head visibility 1 cycle, read data combinational.
// Push is ignored when full and pop when empty; flush wins over both.
module zeroriscy_instr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head, tail;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[head];

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wdata;
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop)  head <= head + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/zeroriscy_instr_gen.sv
// Encodes symbolic RV32IM commands into a FIFO and serves them on the req/gnt/rvalid fetch port.
// Push to grantable 1 cycle, grant to rvalid 1 cycle; cmd_ready drops while full, grant needs a word.
module zeroriscy_instr_gen
  import zeroriscy_defines::*;
  import zeroriscy_instr_gen_defines::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  instr_op_e                  cmd_op_i,
  input  logic [4:0]                 cmd_rd_i,
  input  logic [4:0]                 cmd_rs1_i,
  input  logic [4:0]                 cmd_rs2_i,
  input  logic [31:0]                cmd_imm_i,
  input  logic                       flush_i,
  input  logic                       instr_req_i,
  input  logic [31:0]                instr_addr_i,
  output logic                       instr_gnt_o,
  output logic                       instr_rvalid_o,
  output logic [31:0]                instr_rdata_o,
  output logic                       addr_err_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  function automatic logic [31:0] encode(instr_op_e op, logic [4:0] rd, logic [4:0] rs1,
                                         logic [4:0] rs2, logic [31:0] imm);
    logic [31:0] w;
    w = '0;
    case (op)
      OP_LUI:     w = enc_u(imm[31:12], rd, OPCODE_LUI);
      OP_AUIPC:   w = enc_u(imm[31:12], rd, OPCODE_AUIPC);
      OP_JAL:     w = enc_j(imm[20:1], rd, OPCODE_JAL);
      OP_JALR:    w = enc_i(imm[11:0], rs1, F3_JALR, rd, OPCODE_JALR);
      OP_BEQ:     w = enc_b(imm[12:1], rs2, rs1, F3_BEQ, OPCODE_BRANCH);
      OP_BNE:     w = enc_b(imm[12:1], rs2, rs1, F3_BNE, OPCODE_BRANCH);
      OP_BLT:     w = enc_b(imm[12:1], rs2, rs1, F3_BLT, OPCODE_BRANCH);
      OP_BGE:     w = enc_b(imm[12:1], rs2, rs1, F3_BGE, OPCODE_BRANCH);
      OP_BLTU:    w = enc_b(imm[12:1], rs2, rs1, F3_BLTU, OPCODE_BRANCH);
      OP_BGEU:    w = enc_b(imm[12:1], rs2, rs1, F3_BGEU, OPCODE_BRANCH);
      OP_LB:      w = enc_i(imm[11:0], rs1, F3_B, rd, OPCODE_LOAD);
      OP_LH:      w = enc_i(imm[11:0], rs1, F3_H, rd, OPCODE_LOAD);
      OP_LW:      w = enc_i(imm[11:0], rs1, F3_W, rd, OPCODE_LOAD);
      OP_LBU:     w = enc_i(imm[11:0], rs1, F3_BU, rd, OPCODE_LOAD);
      OP_LHU:     w = enc_i(imm[11:0], rs1, F3_HU, rd, OPCODE_LOAD);
      OP_SB:      w = enc_s(imm[11:0], rs2, rs1, F3_B, OPCODE_STORE);
      OP_SH:      w = enc_s(imm[11:0], rs2, rs1, F3_H, OPCODE_STORE);
      OP_SW:      w = enc_s(imm[11:0], rs2, rs1, F3_W, OPCODE_STORE);
      OP_ADDI:    w = enc_i(imm[11:0], rs1, F3_ADD, rd, OPCODE_OPIMM);
      OP_SLTI:    w = enc_i(imm[11:0], rs1, F3_SLT, rd, OPCODE_OPIMM);
      OP_SLTIU:   w = enc_i(imm[11:0], rs1, F3_SLTU, rd, OPCODE_OPIMM);
      OP_XORI:    w = enc_i(imm[11:0], rs1, F3_XOR, rd, OPCODE_OPIMM);
      OP_ORI:     w = enc_i(imm[11:0], rs1, F3_OR, rd, OPCODE_OPIMM);
      OP_ANDI:    w = enc_i(imm[11:0], rs1, F3_AND, rd, OPCODE_OPIMM);
      OP_SLLI:    w = enc_i({F7_BASE, imm[4:0]}, rs1, F3_SLL, rd, OPCODE_OPIMM);
      OP_SRLI:    w = enc_i({F7_BASE, imm[4:0]}, rs1, F3_SR, rd, OPCODE_OPIMM);
      OP_SRAI:    w = enc_i({F7_ALT, imm[4:0]}, rs1, F3_SR, rd, OPCODE_OPIMM);
      OP_ADD:     w = enc_r(F7_BASE, rs2, rs1, F3_ADD, rd, OPCODE_OP);
      OP_SUB:     w = enc_r(F7_ALT, rs2, rs1, F3_ADD, rd, OPCODE_OP);
      OP_SLL:     w = enc_r(F7_BASE, rs2, rs1, F3_SLL, rd, OPCODE_OP);
      OP_SLT:     w = enc_r(F7_BASE, rs2, rs1, F3_SLT, rd, OPCODE_OP);
      OP_SLTU:    w = enc_r(F7_BASE, rs2, rs1, F3_SLTU, rd, OPCODE_OP);
      OP_XOR:     w = enc_r(F7_BASE, rs2, rs1, F3_XOR, rd, OPCODE_OP);
      OP_SRL:     w = enc_r(F7_BASE, rs2, rs1, F3_SR, rd, OPCODE_OP);
      OP_SRA:     w = enc_r(F7_ALT, rs2, rs1, F3_SR, rd, OPCODE_OP);
      OP_OR:      w = enc_r(F7_BASE, rs2, rs1, F3_OR, rd, OPCODE_OP);
      OP_AND:     w = enc_r(F7_BASE, rs2, rs1, F3_AND, rd, OPCODE_OP);
      OP_FENCE:   w = enc_i(imm[11:0], rs1, F3_FENCE, rd, OPCODE_FENCE);
      OP_MUL:     w = enc_r(F7_MULDIV, rs2, rs1, F3_MUL, rd, OPCODE_OP);
      OP_MULH:    w = enc_r(F7_MULDIV, rs2, rs1, F3_MULH, rd, OPCODE_OP);
      OP_MULHSU:  w = enc_r(F7_MULDIV, rs2, rs1, F3_MULHSU, rd, OPCODE_OP);
      OP_MULHU:   w = enc_r(F7_MULDIV, rs2, rs1, F3_MULHU, rd, OPCODE_OP);
      OP_DIV:     w = enc_r(F7_MULDIV, rs2, rs1, F3_DIV, rd, OPCODE_OP);
      OP_DIVU:    w = enc_r(F7_MULDIV, rs2, rs1, F3_DIVU, rd, OPCODE_OP);
      OP_REM:     w = enc_r(F7_MULDIV, rs2, rs1, F3_REM, rd, OPCODE_OP);
      OP_REMU:    w = enc_r(F7_MULDIV, rs2, rs1, F3_REMU, rd, OPCODE_OP);
      OP_ECALL:   w = INSTR_ECALL;
      OP_EBREAK:  w = INSTR_EBREAK;
      OP_MRET:    w = INSTR_MRET;
      OP_WFI:     w = INSTR_WFI;
      // rs1 carries the 5-bit zimm for the immediate CSR forms.
      OP_CSRRW:   w = enc_i(imm[11:0], rs1, F3_CSRRW, rd, OPCODE_SYSTEM);
      OP_CSRRS:   w = enc_i(imm[11:0], rs1, F3_CSRRS, rd, OPCODE_SYSTEM);
      OP_CSRRC:   w = enc_i(imm[11:0], rs1, F3_CSRRC, rd, OPCODE_SYSTEM);
      OP_CSRRWI:  w = enc_i(imm[11:0], rs1, F3_CSRRWI, rd, OPCODE_SYSTEM);
      OP_CSRRSI:  w = enc_i(imm[11:0], rs1, F3_CSRRSI, rd, OPCODE_SYSTEM);
      OP_CSRRCI:  w = enc_i(imm[11:0], rs1, F3_CSRRCI, rd, OPCODE_SYSTEM);
      OP_MMULT32: w = enc_r(imm[6:0], rs2, rs1, F3_MMULT32, rd, OPCODE_OP);
      default:    w = '0;
    endcase
    return w;
  endfunction

  logic        fifo_full, fifo_empty;
  logic [31:0] cmd_word, head_word;
  logic [31:0] exp_pc;

  assign cmd_word    = encode(cmd_op_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i, cmd_imm_i);
  assign cmd_ready_o = !fifo_full;
  assign instr_gnt_o = instr_req_i && !fifo_empty && !flush_i;

  zeroriscy_instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_i),
    .push  (cmd_valid_i && cmd_ready_o),
    .wdata (cmd_word),
    .pop   (instr_gnt_o),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (level_o)
  );

  // exp_pc always follows the last granted address so a jump costs one error, not a cascade.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_rvalid_o <= 1'b0;
      instr_rdata_o  <= '0;
      addr_err_o     <= 1'b0;
      exp_pc         <= BOOT_ADDR;
    end else begin
      instr_rvalid_o <= instr_gnt_o;
      if (instr_gnt_o) begin
        instr_rdata_o <= head_word;
        exp_pc        <= instr_addr_i + 32'd4;
        if (instr_addr_i != exp_pc) addr_err_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_zeroriscy_instr_gen.sv
// Directed plus randomized bench for zeroriscy_instr_gen against a queue-based reference model.
module tb_zeroriscy_instr_gen;
  import zeroriscy_instr_gen_defines::*;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BOOT  = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  instr_op_e   cmd_op;
  logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [31:0] cmd_imm;
  logic        flush;
  logic        instr_req, instr_gnt, instr_rvalid, addr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic [3:0]  level;

  always #5 clk = ~clk;

  zeroriscy_instr_gen #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_op_i       (cmd_op),
    .cmd_rd_i       (cmd_rd),
    .cmd_rs1_i      (cmd_rs1),
    .cmd_rs2_i      (cmd_rs2),
    .cmd_imm_i      (cmd_imm),
    .flush_i        (flush),
    .instr_req_i    (instr_req),
    .instr_addr_i   (instr_addr),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .addr_err_o     (addr_err),
    .level_o        (level)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder: pick format and field values from the ISA tables, then place fields arithmetically.
  function automatic logic [31:0] ref_encode(instr_op_e op, logic [4:0] rd, logic [4:0] rs1,
                                             logic [4:0] rs2, logic [31:0] imm);
    int          f3, f7, opc, idx;
    byte         fmt;
    logic [31:0] iv, x;
    int          t_opimm[6], t_r3[10], t_csr[6];
    t_opimm = '{0, 2, 3, 4, 6, 7};
    t_r3    = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    t_csr   = '{1, 2, 3, 5, 6, 7};
    f3 = 0; f7 = 0; opc = 'h33; fmt = "R"; iv = imm; x = 0; idx = 0;
    if (op == OP_LUI)        begin fmt = "U"; opc = 'h37; end
    else if (op == OP_AUIPC) begin fmt = "U"; opc = 'h17; end
    else if (op == OP_JAL)   begin fmt = "J"; opc = 'h6f; end
    else if (op == OP_JALR)  begin fmt = "I"; opc = 'h67; end
    else if (op >= OP_BEQ && op <= OP_BGEU) begin
      idx = int'(op) - int'(OP_BEQ); fmt = "B"; opc = 'h63; f3 = (idx < 2) ? idx : idx + 2;
    end else if (op >= OP_LB && op <= OP_LHU) begin
      idx = int'(op) - int'(OP_LB); fmt = "I"; opc = 'h03; f3 = (idx < 3) ? idx : idx + 1;
    end else if (op >= OP_SB && op <= OP_SW) begin
      fmt = "S"; opc = 'h23; f3 = int'(op) - int'(OP_SB);
    end else if (op >= OP_ADDI && op <= OP_ANDI) begin
      fmt = "I"; opc = 'h13; f3 = t_opimm[int'(op) - int'(OP_ADDI)];
    end else if (op >= OP_SLLI && op <= OP_SRAI) begin
      fmt = "I"; opc = 'h13; f3 = (op == OP_SLLI) ? 1 : 5;
      iv = (imm % 32) + ((op == OP_SRAI) ? 32'h400 : 32'h0);
    end else if (op >= OP_ADD && op <= OP_AND) begin
      f3 = t_r3[int'(op) - int'(OP_ADD)]; f7 = (op == OP_SUB || op == OP_SRA) ? 32 : 0;
    end else if (op == OP_FENCE) begin fmt = "I"; opc = 'h0f; end
    else if (op >= OP_MUL && op <= OP_REMU) begin f7 = 1; f3 = int'(op) - int'(OP_MUL); end
    else if (op == OP_ECALL)  begin fmt = "X"; x = 32'h0000_0073; end
    else if (op == OP_EBREAK) begin fmt = "X"; x = 32'h0010_0073; end
    else if (op == OP_MRET)   begin fmt = "X"; x = 32'h3020_0073; end
    else if (op == OP_WFI)    begin fmt = "X"; x = 32'h1050_0073; end
    else if (op >= OP_CSRRW && op <= OP_CSRRCI) begin
      fmt = "I"; opc = 'h73; f3 = t_csr[int'(op) - int'(OP_CSRRW)];
    end else begin f7 = int'(imm % 128); f3 = 5; end
    case (fmt)
      "R": x = 32'(f7) * 2**25 + 32'(rs2) * 2**20 + 32'(rs1) * 2**15 + 32'(f3) * 2**12 + 32'(rd) * 2**7 + 32'(opc);
      "I": x = (iv % 4096) * 2**20 + 32'(rs1) * 2**15 + 32'(f3) * 2**12 + 32'(rd) * 2**7 + 32'(opc);
      "S": x = ((iv / 32) % 128) * 2**25 + 32'(rs2) * 2**20 + 32'(rs1) * 2**15 + 32'(f3) * 2**12
               + (iv % 32) * 2**7 + 32'(opc);
      "B": x = ((iv / 4096) % 2) * 2**31 + ((iv / 32) % 64) * 2**25 + 32'(rs2) * 2**20 + 32'(rs1) * 2**15
               + 32'(f3) * 2**12 + ((iv / 2) % 16) * 2**8 + ((iv / 2048) % 2) * 2**7 + 32'(opc);
      "U": x = (iv / 4096) * 4096 + 32'(rd) * 2**7 + 32'(opc);
      "J": x = ((iv / 2**20) % 2) * 2**31 + ((iv / 2) % 1024) * 2**21 + ((iv / 2048) % 2) * 2**20
               + ((iv / 4096) % 256) * 2**12 + 32'(rd) * 2**7 + 32'(opc);
      default: ;
    endcase
    return x;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_err    = 1'b0;
    m_pc     = BOOT;
  endtask

  task automatic set_cmd(input logic v, input instr_op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
    cmd_valid = v; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
  endtask

  task automatic rand_cmd(input logic v);
    set_cmd(v, instr_op_e'($urandom_range(0, int'(OP_MMULT32))), 5'($urandom), 5'($urandom),
            5'($urandom), $urandom);
  endtask

  task automatic set_fetch(input logic r, input logic [31:0] a);
    instr_req = r; instr_addr = a;
  endtask

  // One clock: check combinational outputs, advance DUT and model together, check registered outputs.
  task automatic tick();
    logic        exp_rdy, exp_gnt;
    logic [31:0] w;
    #1;
    exp_rdy = (mq.size() < DEPTH);
    exp_gnt = instr_req && (mq.size() != 0) && !flush;
    check("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
    check("instr_gnt", 32'(instr_gnt), 32'(exp_gnt));
    w = ref_encode(cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm);
    @(posedge clk);
    m_rvalid = exp_gnt;
    if (flush) mq.delete();
    else begin
      if (exp_gnt) begin
        m_rdata = mq.pop_front();
        if (instr_addr != m_pc) m_err = 1'b1;
        m_pc = instr_addr + 32'd4;
      end
      if (cmd_valid && exp_rdy) mq.push_back(w);
    end
    #1;
    check("instr_rvalid", 32'(instr_rvalid), 32'(m_rvalid));
    check("instr_rdata", instr_rdata, m_rdata);
    check("addr_err", 32'(addr_err), 32'(m_err));
    check("level", 32'(level), 32'(mq.size()));
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    set_cmd(1'b0, OP_ADDI, 0, 0, 0, 0);
    set_fetch(1'b1, BOOT);
    model_reset();
    #12;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_gnt", 32'(instr_gnt), 32'd0);
    check("rst_rvalid", 32'(instr_rvalid), 32'd0);
    check("rst_rdata", instr_rdata, 32'd0);
    check("rst_err", 32'(addr_err), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    set_fetch(1'b0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADDI with all-ones immediate, fetched from the boot address
    set_cmd(1'b1, OP_ADDI, 1, 2, 0, 32'hFFFF_FFFF);
    tick();
    set_cmd(1'b0, OP_ADDI, 0, 0, 0, 0);
    set_fetch(1'b1, 32'h80);
    #1; check("t1_gnt_same_cycle", 32'(instr_gnt), 32'd1);
    tick();
    check("t1_rvalid", 32'(instr_rvalid), 32'd1);
    check("t1_rdata", instr_rdata, 32'hFFF1_0093);
    set_fetch(1'b0, 0);
    tick();
    check("t1_rdata_hold", instr_rdata, 32'hFFF1_0093);

    // LUI, JAL, MRET fetched back to back
    set_cmd(1'b1, OP_LUI, 5, 0, 0, 32'h1234_5000); tick();
    set_cmd(1'b1, OP_JAL, 0, 0, 0, 32'd8); tick();
    set_cmd(1'b1, OP_MRET, 7, 3, 4, 32'hFFFF_FFFF); tick();
    set_cmd(1'b0, OP_ADDI, 0, 0, 0, 0);
    set_fetch(1'b1, 32'h84); tick(); check("t2_lui", instr_rdata, 32'h1234_52B7);
    set_fetch(1'b1, 32'h88); tick(); check("t2_jal", instr_rdata, 32'h0080_006F);
    set_fetch(1'b1, 32'h8C); tick(); check("t2_mret", instr_rdata, 32'h3020_0073);
    check("t2_rvalid", 32'(instr_rvalid), 32'd1);
    set_fetch(1'b0, 0);

    // Fill to DEPTH, hold the next command, release it with a single grant
    for (int i = 0; i < DEPTH; i++) begin rand_cmd(1'b1); tick(); end
    check("t3_ready_full", 32'(cmd_ready), 32'd0);
    check("t3_level_full", 32'(level), 32'(DEPTH));
    rand_cmd(1'b1);
    tick();
    set_fetch(1'b1, m_pc);
    tick();
    check("t3_ready_after_pop", 32'(cmd_ready), 32'd1);
    set_fetch(1'b0, 0);
    tick();
    check("t3_level_refill", 32'(level), 32'(DEPTH));
    set_cmd(1'b0, OP_ADDI, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin set_fetch(1'b1, m_pc); tick(); end
    check("t3_level_drained", 32'(level), 32'd0);
    set_fetch(1'b0, 0);

    // Flush with 3 buffered words and a concurrent push; prior grant's rvalid still delivered
    for (int i = 0; i < 4; i++) begin rand_cmd(1'b1); tick(); end
    set_cmd(1'b0, OP_ADDI, 0, 0, 0, 0);
    set_fetch(1'b1, 32'h200);
    tick();
    check("t5_level3", 32'(level), 32'd3);
    rand_cmd(1'b1);
    flush = 1'b1;
    set_fetch(1'b1, m_pc);
    #1;
    check("t5_flush_no_gnt", 32'(instr_gnt), 32'd0);
    check("t5_rvalid_owed", 32'(instr_rvalid), 32'd1);
    check("t5_ready_in_flush", 32'(cmd_ready), 32'd1);
    tick();
    check("t5_level_flushed", 32'(level), 32'd0);
    flush = 1'b0;
    set_cmd(1'b0, OP_ADDI, 0, 0, 0, 0);
    set_fetch(1'b0, 0);

    // Reset while an rvalid is owed and 4 words are buffered
    for (int i = 0; i < 4; i++) begin rand_cmd(1'b1); tick(); end
    set_cmd(1'b0, OP_ADDI, 0, 0, 0, 0);
    set_fetch(1'b1, m_pc);
    #1; check("t6_gnt_before_rst", 32'(instr_gnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_ready", 32'(cmd_ready), 32'd1);
    check("t6_gnt", 32'(instr_gnt), 32'd0);
    check("t6_rvalid", 32'(instr_rvalid), 32'd0);
    check("t6_rdata", instr_rdata, 32'd0);
    check("t6_err", 32'(addr_err), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    @(posedge clk); #1;
    check("t6_rvalid_dropped", 32'(instr_rvalid), 32'd0);
    set_fetch(1'b0, 0);
    rst_n = 1'b1;
    model_reset();

    // Sticky address error: 0x80, 0x84 sequential, 0x90 jumps, 0x94 resynced
    for (int i = 0; i < 4; i++) begin rand_cmd(1'b1); tick(); end
    set_cmd(1'b0, OP_ADDI, 0, 0, 0, 0);
    set_fetch(1'b1, 32'h80); tick(); check("t4_err_80", 32'(addr_err), 32'd0);
    set_fetch(1'b1, 32'h84); tick(); check("t4_err_84", 32'(addr_err), 32'd0);
    set_fetch(1'b1, 32'h90); tick(); check("t4_err_90", 32'(addr_err), 32'd1);
    set_fetch(1'b1, 32'h94); tick(); check("t4_err_94", 32'(addr_err), 32'd1);
    set_fetch(1'b0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rand_cmd($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      set_fetch($urandom_range(0, 2) != 0,
                ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFFFF_FFFC) : m_pc);
      tick();
    end
    flush = 1'b0;
    set_cmd(1'b0, OP_ADDI, 0, 0, 0, 0);
    set_fetch(1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/zeroriscy_instr_gen.md
# zeroriscy_instr_gen

Synthesizable RV32IM instruction encoder and fetch responder: the encode direction of the tracer's instruction decode masks. It accepts symbolic instruction commands (operation, register indices, immediate), encodes each into a 32-bit RV32 word, buffers the words in a FIFO, and serves them to the core's instruction fetch port through the req/gnt/rvalid protocol. It sits in place of instruction memory in directed-stimulus and bring-up testbenches, and also checks that the fetch stream stays sequential.

## Interface
- `DEPTH`, default 8: FIFO entries; must be a power of 2 and ≥ 2.
- `BOOT_ADDR`, default 32'h0000_0080: expected address of the first fetch.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command accepted when high together with valid.
- `cmd_op_i`  in  `instr_op_e`  operation (LUI…MMULT32, full RV32IM + SYSTEM set).
- `cmd_rd_i`, `cmd_rs1_i`, `cmd_rs2_i`  in  5 each  register fields (rs1 is also the zimm field for CSR*I).
- `cmd_imm_i`  in  32  immediate; for CSR ops, `[11:0]` is the CSR address.
- `flush_i`  in  1  discard all buffered words.
- `instr_req_i`  in  1  fetch request from core.
- `instr_addr_i`  in  32  fetch address.
- `instr_gnt_o`  out  1  fetch granted.
- `instr_rvalid_o`  out  1  fetch data valid.
- `instr_rdata_o`  out  32  fetched instruction word.
- `addr_err_o`  out  1  sticky: a non-sequential fetch address was seen.
- `level_o`  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Encoding is combinational from the command fields, using standard RV32 formats.
  - R-type: funct7/funct3 per operation.
  - I-type: `imm[11:0]`.
  - SLLI/SRLI/SRAI: shamt = `imm[4:0]` with funct7 as specified.
  - S-type: `imm[11:5]`/`imm[4:0]`.
  - B-type: `imm[12:1]`.
  - U-type: `imm[31:12]`.
  - J-type: `imm[20:1]`.
  - `imm[0]` is ignored for B and J.
  - ECALL/EBREAK/MRET/WFI use fixed words; all register fields are forced to 0.
  - MMULT32: funct7 = `imm[6:0]`, funct3 = 3'b101.
- Push: the encoded word is written to the FIFO tail on the clock edge where `cmd_valid_i && cmd_ready_o`.
- `cmd_ready_o` = !full. It is not raised for a same-cycle pop when full.
- Grant: `instr_gnt_o` = `instr_req_i && !empty && !flush_i`, combinational. On a granted edge the head word is popped into the rdata register.
- `instr_rvalid_o` is high exactly one cycle after each grant. `instr_rdata_o` holds its value until the next rvalid.
- Address check:
  - `exp_pc` resets to `BOOT_ADDR`.
  - On every grant, if `instr_addr_i != exp_pc`, set `addr_err_o` (sticky until reset).
  - Always load `exp_pc <= instr_addr_i + 4`, which resyncs after a jump. Arithmetic is mod 2^32.
- Flush: clears head, tail and count. It has priority over a same-cycle push (command dropped, `cmd_ready_o` stays high) and suppresses grant. It does not cancel an rvalid already owed for a grant in the previous cycle.
- Simultaneous push and pop when not full and not empty: count is unchanged, and both pointers advance with wrap at `DEPTH`.
- Reset values:
  - `cmd_ready_o`=1.
  - `instr_gnt_o`=0 (req-gated, FIFO empty).
  - `instr_rvalid_o`=0.
  - `instr_rdata_o`=0.
  - `addr_err_o`=0.
  - `level_o`=0.
  - `exp_pc`=`BOOT_ADDR`.
- Reset mid-transaction drops any pending rvalid.

## Timing
- Command accept to grantable: 1 cycle (word visible at head the cycle after the push edge).
- Grant to data: 1 cycle. Back-to-back grants are allowed every cycle while the FIFO is non-empty.
- Minimum command-to-rvalid latency: 2 cycles after the push edge.
- All outputs are registered except `instr_gnt_o` and `cmd_ready_o`.

## Structure
- Package `zeroriscy_instr_gen_defines`:
  - `instr_op_e` enum.
  - funct3/funct7 localparams.
  - Fixed-word constants for ECALL/EBREAK/MRET/WFI.
  - Imports `OPCODE_*` from `zeroriscy_defines`.
- Sub-module `zeroriscy_instr_fifo`: parameterized DEPTH×32 synchronous FIFO with flush, full, empty and count.
- The encoder is a function in the top module.

## Test plan
- ADDI rd=1, rs1=2, imm=32'hFFFF_FFFF, then req at 0x80 → gnt same cycle; next cycle rvalid with rdata 32'hFFF1_0093.
- LUI rd=5, imm=32'h1234_5000; JAL rd=0, imm=8; MRET → three back-to-back fetches return 32'h1234_52B7, 32'h0080_006F, 32'h3020_0073 on consecutive cycles.
- Push `DEPTH` commands with no req → `cmd_ready_o`=0 and `level_o`=`DEPTH`. The next command is held; one grant → ready high the next cycle.
- Fetch addresses 0x80, 0x84, 0x90 → `addr_err_o` rises after the 0x90 grant and stays high. A following fetch at 0x94 raises no new error.
- `flush_i` with 3 words buffered plus a concurrent push → `level_o`=0 and no grant that cycle. The rvalid from the prior-cycle grant is still delivered.
- Assert `rst_n` low while rvalid is owed and 4 words are buffered → all outputs take their reset values immediately; `exp_pc` is back to 0x80.
